// File: rtl/fft_pkg.sv
// Shared error codes and control-state encoding for the FFT block-floating-point normaliser.
package fft_pkg;

  localparam logic [1:0] ERR_NONE      = 2'b00;
  localparam logic [1:0] ERR_MISS_SOP  = 2'b01;
  localparam logic [1:0] ERR_MISS_EOP  = 2'b10;
  localparam logic [1:0] ERR_UNEXP_EOP = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/fft_bfp_ram.sv
// Simple dual-port frame buffer: one write port, one read port with a registered,
// enable-gated output so a stalled read holds its data.
module fft_bfp_ram #(
  parameter int W  = 48,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fft_bfp_normalizer.sv
// Frame-buffering block-floating-point normaliser for FFT output streams.
// Normalisation (redundant-sign tracker + shifter) is compiled in only with FFT_BFP_NORM_EN.
module fft_bfp_normalizer
  import fft_pkg::*;
#(
  parameter int DATA_W   = 24,
  parameter int LOG2_LEN = 10,
  parameter int EXP_W    = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sink_valid,
  output logic              sink_ready,
  input  logic              sink_sop,
  input  logic              sink_eop,
  input  logic [DATA_W-1:0] sink_real,
  input  logic [DATA_W-1:0] sink_imag,
  input  logic              inverse,
  output logic              source_valid,
  input  logic              source_ready,
  output logic              source_sop,
  output logic              source_eop,
  output logic [DATA_W-1:0] source_real,
  output logic [DATA_W-1:0] source_imag,
  output logic [EXP_W-1:0]  source_exp,
  output logic [1:0]        source_error
);

  localparam int N      = 2**LOG2_LEN;
  localparam int AW     = LOG2_LEN;
  localparam int SW     = $clog2(DATA_W);
  localparam int STAGES = 2;
  localparam logic [AW-1:0] LAST = AW'(N-1);
  localparam logic signed [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] SMAX = ~SMIN;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_cnt_q, wr_cnt_d, waddr;
  logic [1:0]      err_d;
  logic            inv_q;
  logic            sink_xfer, src_xfer, start_frame, fill_beat, we;

  assign sink_ready   = (state_q != ST_DRAIN) && !reset;
  assign sink_xfer    = sink_valid && sink_ready;
  assign src_xfer     = source_valid && source_ready;

  // ---------------- frame capture FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      wr_cnt_q     <= '0;
      source_error <= ERR_NONE;
      inv_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      source_error <= err_d;
      if (start_frame) inv_q <= inverse;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    err_d       = source_error;
    start_frame = 1'b0;
    fill_beat   = 1'b0;
    we          = 1'b0;
    waddr       = wr_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (sink_xfer) begin
          if (sink_sop) begin
            start_frame = 1'b1;
            we          = 1'b1;
            waddr       = '0;
            wr_cnt_d    = AW'(1);
            state_d     = ST_FILL;
          end else begin
            err_d = ERR_MISS_SOP;
          end
        end
      end
      ST_FILL: begin
        if (sink_xfer) begin
          if (sink_sop) begin
            // a restarting sop is dropped along with the partial frame
            err_d   = ERR_MISS_EOP;
            state_d = ST_IDLE;
          end else begin
            we        = 1'b1;
            fill_beat = 1'b1;
            if (wr_cnt_q == LAST) begin
              if (sink_eop) begin
                err_d   = ERR_NONE;
                state_d = ST_DRAIN;
              end else begin
                err_d   = ERR_MISS_EOP;
                state_d = ST_IDLE;
              end
            end else if (sink_eop) begin
              err_d   = ERR_UNEXP_EOP;
              state_d = ST_IDLE;
            end else begin
              wr_cnt_d = wr_cnt_q + AW'(1);
            end
          end
        end
      end
      ST_DRAIN: begin
        if (src_xfer && source_eop) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- block exponent ----------------
  logic [SW-1:0] shift;

`ifdef FFT_BFP_NORM_EN
  localparam int SCLAMP = (DATA_W-1 < 2**(EXP_W-1)) ? DATA_W-1 : 2**(EXP_W-1);

  // leading bits equal to the sign, excluding the sign itself
  function automatic logic [SW-1:0] rsb(input logic [DATA_W-1:0] x);
    logic [SW-1:0] n;
    logic          run;
    n   = '0;
    run = 1'b1;
    for (int i = DATA_W-2; i >= 0; i--) begin
      if (run && (x[i] == x[DATA_W-1])) n = n + SW'(1);
      else run = 1'b0;
    end
    return n;
  endfunction

  logic [SW-1:0] s_re, s_im, s_beat, s_trk;

  always_comb begin
    s_re   = rsb(sink_real);
    s_im   = rsb(sink_imag);
    s_beat = (s_re < s_im) ? s_re : s_im;
    if (s_beat > SW'(SCLAMP)) s_beat = SW'(SCLAMP);
  end

  always_ff @(posedge clk) begin
    if (reset)                             s_trk <= SW'(DATA_W-1);
    else if (start_frame)                  s_trk <= s_beat;
    else if (fill_beat && s_beat < s_trk)  s_trk <= s_beat;
  end

  assign shift = s_trk;
`else
  assign shift = '0;
`endif

  // ---------------- drain pipeline: RAM read -> output register ----------------
  logic [STAGES:1]     vld_pipe;
  logic [AW-1:0]       rd_cnt_q, rd_tag_q;
  logic                rd_done_q, rd_req, rd_en, adv;
  logic [2*DATA_W-1:0] rd_data;
  logic signed [DATA_W-1:0] rd_re, rd_im, sh_re, sh_im, out_im;

  fft_bfp_ram #(.W(2*DATA_W), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata ({sink_real, sink_imag}),
    .re    (rd_en),
    .raddr (rd_cnt_q),
    .rdata (rd_data)
  );

  // whole pipeline advances together; a stalled output freezes the RAM read too
  assign adv    = !vld_pipe[STAGES] || source_ready;
  assign rd_req = (state_q == ST_DRAIN) && !rd_done_q;
  assign rd_en  = rd_req && adv;

  assign rd_re  = rd_data[2*DATA_W-1:DATA_W];
  assign rd_im  = rd_data[DATA_W-1:0];
  assign sh_re  = rd_re <<< shift;
  assign sh_im  = rd_im <<< shift;
  assign out_im = !inv_q ? sh_im : ((sh_im == SMIN) ? SMAX : -sh_im);

  assign source_valid = vld_pipe[STAGES];

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt_q    <= '0;
      rd_done_q   <= 1'b0;
      rd_tag_q    <= '0;
      vld_pipe    <= '0;
      source_sop  <= 1'b0;
      source_eop  <= 1'b0;
      source_real <= '0;
      source_imag <= '0;
      source_exp  <= '0;
    end else begin
      if (state_q != ST_DRAIN) begin
        rd_cnt_q  <= '0;
        rd_done_q <= 1'b0;
      end else if (rd_en) begin
        rd_cnt_q <= rd_cnt_q + AW'(1);
        if (rd_cnt_q == LAST) rd_done_q <= 1'b1;
      end
      if (adv) begin
        vld_pipe <= {vld_pipe[STAGES-1:1], rd_en};
        if (rd_en) rd_tag_q <= rd_cnt_q;
        if (vld_pipe[1]) begin
          source_real <= sh_re;
          source_imag <= out_im;
          source_exp  <= -EXP_W'(shift);
          source_sop  <= (rd_tag_q == '0);
          source_eop  <= (rd_tag_q == LAST);
        end else begin
          source_sop <= 1'b0;
          source_eop <= 1'b0;
        end
      end
    end
  end

endmodule
